// File: rtl/rsff_bank_arbiter.sv
// Shared set/reset flag bank with a two-cycle IDLE/ARB write arbiter.
// Define RSFF_ARB_ROUNDROBIN_EN for round-robin arbitration; default is fixed priority (lowest index).
module rsff_bank_arbiter #(
    parameter int unsigned     NREQ      = 4,
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     IDXW      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 busy
);

    localparam int unsigned WW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ARB  = 1'b1;

    logic [0:0]       state_q;
    logic [NREQ-1:0]  gnt_q;
    logic             win_op_q;
    logic [IDXW-1:0]  win_idx_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WW-1:0]    win_d;

`ifdef RSFF_ARB_ROUNDROBIN_EN
    logic [WW-1:0] ptr_q;
    logic          found;

    // Search starts at the round-robin pointer and wraps around.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[(32'(ptr_q) + k) % NREQ]) begin
                win_d = WW'((32'(ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: descending scan leaves the lowest requesting index.
    always_comb begin
        win_d = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req[k]) win_d = WW'(k);
        end
    end
`endif

    // Out-of-range indices match no bit, so the write is dropped; clr_all wins over a write.
    always_comb begin
        q_d = q_q;
        if (clr_all) begin
            q_d = '0;
        end else if (state_q == ARB) begin
            for (int unsigned b = 0; b < WIDTH; b++) begin
                if (32'(win_idx_q) == b) q_d[b] = win_op_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            win_op_q  <= 1'b0;
            win_idx_q <= '0;
            q_q       <= RESET_VAL;
`ifdef RSFF_ARB_ROUNDROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            q_q <= q_d;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q   <= ARB;
                        gnt_q     <= NREQ'(1) << win_d;
                        win_op_q  <= op[win_d];
                        win_idx_q <= idx[win_d*IDXW +: IDXW];
`ifdef RSFF_ARB_ROUNDROBIN_EN
                        ptr_q     <= (32'(win_d) == NREQ - 1) ? '0 : win_d + 1'b1;
`endif
                    end
                end
                ARB: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign busy = (state_q == ARB);

endmodule

// File: tb/tb_rsff_bank_arbiter.sv
// Directed self-checking bench for rsff_bank_arbiter (NREQ=4, WIDTH=8, IDXW=4, RESET_VAL=8'hA5).
module tb_rsff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [15:0] idx;
    logic        clr_all;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;

    int tests = 0;
    int fails = 0;

    rsff_bank_arbiter #(
        .NREQ      (4),
        .WIDTH     (8),
        .IDXW      (4),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .idx     (idx),
        .clr_all (clr_all),
        .gnt     (gnt),
        .q       (q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] exp_gnt;

    initial begin
        reset = 1'b1; req = '0; op = '0; idx = '0; clr_all = 1'b0;
        tick();
        chk("rst_q", 32'(q), 32'hA5);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // 1: reset mid-ARB discards the pending clear of bit 0
        req = 4'b0001; op = 4'b0000; idx = 16'h0000;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        req = '0;
        #2 reset = 1'b1;
        #1;
        chk("t1_async_q", 32'(q), 32'hA5);
        chk("t1_async_gnt", 32'(gnt), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        chk("t1_nowrite_q", 32'(q), 32'hA5);

        // 2: single set of bit 3 from zero
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("t2_clr_q", 32'(q), 32'h00);
        req = 4'b0001; op = 4'b0001; idx = 16'h0003;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h1);
        chk("t2_q_before", 32'(q), 32'h00);
        req = '0;
        tick();
        chk("t2_q_after", 32'(q), 32'h08);
        chk("t2_gnt_off", 32'(gnt), 32'h0);
        chk("t2_busy_off", 32'(busy), 32'h0);

        // 3: all four hold req, each sets its own bit
        do_reset();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        req = 4'b1111; op = 4'b1111; idx = {4'd3, 4'd2, 4'd1, 4'd0};
        for (int r = 0; r < 4; r++) begin
`ifdef RSFF_ARB_ROUNDROBIN_EN
            exp_gnt = 4'b0001 << r;
`else
            exp_gnt = 4'b0001;
`endif
            tick();
            chk($sformatf("t3_gnt%0d", r), 32'(gnt), 32'(exp_gnt));
            tick();
            chk($sformatf("t3_idle%0d", r), 32'(gnt), 32'h0);
        end
        req = '0;
`ifdef RSFF_ARB_ROUNDROBIN_EN
        chk("t3_q", 32'(q), 32'h0F);
`else
        chk("t3_q", 32'(q), 32'h01);
`endif

        // 4: two requesters on bit 5, serialized; the later clear wins
        do_reset();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        req = 4'b0011; op = 4'b0001; idx = {4'd0, 4'd0, 4'd5, 4'd5};
        tick();
        chk("t4_gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("t4_q_set", 32'(q), 32'h20);
        tick();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("t4_q_clr", 32'(q), 32'h00);

        // 5: build q=F0, then clr_all during ARB beats the write of bit 2
        for (int b = 4; b < 8; b++) begin
            req = 4'b0001; op = 4'b0001; idx = 16'(b);
            tick();
            req = '0;
            tick();
        end
        chk("t5_q_f0", 32'(q), 32'hF0);
        req = 4'b0001; op = 4'b0001; idx = 16'h0002;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h1);
        req = '0; clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("t5_q", 32'(q), 32'h00);

        // 6: out-of-range index still grants but leaves q alone
        req = 4'b0001; op = 4'b0001; idx = 16'h0009;
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("t6_q", 32'(q), 32'h00);
        chk("t6_gnt_off", 32'(gnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
